// File: rtl/exe_fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_fwd_hazard_unit_if
// Brief    : ID/EXE inputs and EXE/MEM outputs of the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exe_fwd_hazard_unit_if;
    logic        FWRD_EN;
    logic [31:0] pc;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] val_WB;
    logic [23:0] signed_imm_24;
    logic [11:0] shifter_operand;
    logic [3:0]  exe_cmd;
    logic [3:0]  dest;
    logic [3:0]  status_in;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        S;
    logic        B;
    logic        imm;
    logic [3:0]  src1_fwd;
    logic [3:0]  src2_fwd;
    logic        WB_EN_WB;
    logic [3:0]  dest_WB;
    logic [3:0]  src1_id;
    logic [3:0]  src2_id;
    logic        two_src;
    logic        move;

    logic [31:0] alu_res_MEM;
    logic [31:0] rm_val_MEM;
    logic [3:0]  dest_MEM;
    logic        WB_EN_MEM;
    logic        MEM_R_EN_MEM;
    logic        MEM_W_EN_MEM;
    logic [31:0] branch_address;
    logic [3:0]  status;
    logic        hazard;
    logic [1:0]  sel1;
    logic [1:0]  sel2;

    modport master (
        output FWRD_EN, pc, rn_val, rm_val, val_WB, signed_imm_24, shifter_operand,
               exe_cmd, dest, status_in, WB_EN, MEM_R_EN, MEM_W_EN, S, B, imm,
               src1_fwd, src2_fwd, WB_EN_WB, dest_WB, src1_id, src2_id, two_src, move,
        input  alu_res_MEM, rm_val_MEM, dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
               branch_address, status, hazard, sel1, sel2
    );

    modport slave (
        input  FWRD_EN, pc, rn_val, rm_val, val_WB, signed_imm_24, shifter_operand,
               exe_cmd, dest, status_in, WB_EN, MEM_R_EN, MEM_W_EN, S, B, imm,
               src1_fwd, src2_fwd, WB_EN_WB, dest_WB, src1_id, src2_id, two_src, move,
        output alu_res_MEM, rm_val_MEM, dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
               branch_address, status, hazard, sel1, sel2
    );
endinterface
`default_nettype wire

// File: rtl/exe_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_fwd_hazard_unit
// Brief    : ARM32 execute stage with operand forwarding, NZCV register and
//            load-use / RAW hazard detection for the instruction in ID.
// Revision : 1.0 - initial release
// ============================================================================
module exe_fwd_hazard_unit (
    input  wire logic             clk,
    input  wire logic             rst,
    exe_fwd_hazard_unit_if.slave  bus
);
    localparam logic [1:0] c_SEL_REG = 2'd0;
    localparam logic [1:0] c_SEL_MEM = 2'd1;
    localparam logic [1:0] c_SEL_WB  = 2'd2;

    logic [31:0] r_alu_res;
    logic [31:0] r_rm_val;
    logic [3:0]  r_dest;
    logic        r_wb_en;
    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic [3:0]  r_status;

    logic [1:0]  w_sel1, w_sel2;
    logic [31:0] w_rn, w_rm, w_val2, w_shifted, w_imm_rot, w_res;
    logic [32:0] w_sum;
    logic        w_c, w_v, w_n, w_z;
    logic        w_match1, w_match2;
    logic        w_unused_ok;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // MEM-stage match wins over WB: it carries the younger value.
    always_comb begin
        w_sel1 = c_SEL_REG;
        if (bus.FWRD_EN && r_wb_en && r_dest == bus.src1_fwd)
            w_sel1 = c_SEL_MEM;
        else if (bus.FWRD_EN && bus.WB_EN_WB && bus.dest_WB == bus.src1_fwd)
            w_sel1 = c_SEL_WB;
        w_sel2 = c_SEL_REG;
        if (bus.FWRD_EN && r_wb_en && r_dest == bus.src2_fwd)
            w_sel2 = c_SEL_MEM;
        else if (bus.FWRD_EN && bus.WB_EN_WB && bus.dest_WB == bus.src2_fwd)
            w_sel2 = c_SEL_WB;
    end

    always_comb begin
        case (w_sel1)
            c_SEL_MEM: w_rn = r_alu_res;
            c_SEL_WB:  w_rn = bus.val_WB;
            default:   w_rn = bus.rn_val;
        endcase
        case (w_sel2)
            c_SEL_MEM: w_rm = r_alu_res;
            c_SEL_WB:  w_rm = bus.val_WB;
            default:   w_rm = bus.rm_val;
        endcase
    end

    assign w_imm_rot = ror32({24'd0, bus.shifter_operand[7:0]}, {bus.shifter_operand[11:8], 1'b0});

    always_comb begin
        case (bus.shifter_operand[6:5])
            2'b00:   w_shifted = w_rm << bus.shifter_operand[11:7];
            2'b01:   w_shifted = w_rm >> bus.shifter_operand[11:7];
            2'b10:   w_shifted = 32'($signed(w_rm) >>> bus.shifter_operand[11:7]);
            default: w_shifted = ror32(w_rm, bus.shifter_operand[11:7]);
        endcase
    end

    always_comb begin
        if (bus.imm)
            w_val2 = w_imm_rot;
        else if (bus.MEM_R_EN || bus.MEM_W_EN)
            w_val2 = {20'd0, bus.shifter_operand};
        else
            w_val2 = w_shifted;
    end

    // Subtraction is Rn + ~Val2 + 1 so C reads as "no borrow".
    always_comb begin
        w_res = 32'd0;
        w_sum = 33'd0;
        w_c   = bus.status_in[1];
        w_v   = bus.status_in[0];
        case (bus.exe_cmd)
            4'b0001: w_res = w_val2;
            4'b1001: w_res = ~w_val2;
            4'b0010, 4'b0011: begin
                w_sum = {1'b0, w_rn} + {1'b0, w_val2}
                      + ((bus.exe_cmd == 4'b0011) ? {32'd0, bus.status_in[1]} : 33'd0);
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (w_rn[31] == w_val2[31]) && (w_res[31] != w_rn[31]);
            end
            4'b0100, 4'b0101: begin
                w_sum = {1'b0, w_rn} + {1'b0, ~w_val2}
                      + ((bus.exe_cmd == 4'b0101) ? {32'd0, bus.status_in[1]} : 33'd1);
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (w_rn[31] != w_val2[31]) && (w_res[31] != w_rn[31]);
            end
            4'b0110: w_res = w_rn & w_val2;
            4'b0111: w_res = w_rn | w_val2;
            4'b1000: w_res = w_rn ^ w_val2;
            default: w_res = 32'd0;
        endcase
    end

    assign w_n = w_res[31];
    assign w_z = (w_res == 32'd0);

    // Falling-edge update lets the instruction in ID see fresh flags this cycle.
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            r_status <= 4'd0;
        else if (bus.S)
            r_status <= {w_n, w_z, w_c, w_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_res  <= 32'd0;
            r_rm_val   <= 32'd0;
            r_dest     <= 4'd0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
        end else begin
            r_alu_res  <= w_res;
            r_rm_val   <= w_rm;
            r_dest     <= bus.dest;
            r_wb_en    <= bus.WB_EN;
            r_mem_r_en <= bus.MEM_R_EN;
            r_mem_w_en <= bus.MEM_W_EN;
        end
    end

    always_comb begin
        w_match1 = (bus.WB_EN && bus.src1_id == bus.dest) || (r_wb_en && bus.src1_id == r_dest);
        w_match2 = (bus.WB_EN && bus.src2_id == bus.dest) || (r_wb_en && bus.src2_id == r_dest);
    end

    assign bus.hazard = (bus.FWRD_EN && !bus.MEM_R_EN) ? 1'b0
                      : ((!bus.move && w_match1) || (bus.two_src && w_match2));

    assign bus.branch_address = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

    assign bus.alu_res_MEM  = r_alu_res;
    assign bus.rm_val_MEM   = r_rm_val;
    assign bus.dest_MEM     = r_dest;
    assign bus.WB_EN_MEM    = r_wb_en;
    assign bus.MEM_R_EN_MEM = r_mem_r_en;
    assign bus.MEM_W_EN_MEM = r_mem_w_en;
    assign bus.status       = r_status;
    assign bus.sel1         = w_sel1;
    assign bus.sel2         = w_sel2;

    // B only steers fetch and the N/Z input flags are not consumed here.
    assign w_unused_ok = &{1'b0, bus.B, bus.status_in[3:2]};
endmodule
`default_nettype wire

// File: tb/tb_exe_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_fwd_hazard_unit
// Brief    : Directed vectors with a queue-based scoreboard and monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_fwd_hazard_unit;
    localparam int c_F_ALU = 0, c_F_RM = 1, c_F_DEST = 2, c_F_WBEN = 3, c_F_MRE = 4,
                   c_F_BR = 5, c_F_STAT = 6, c_F_HAZ = 7, c_F_SEL1 = 8, c_F_SEL2 = 9;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   r_q[$];
    event   smp_ev;
    int     n_tests;
    int     n_fail;

    exe_fwd_hazard_unit_if bus ();

    exe_fwd_hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] field(input int f);
        case (f)
            c_F_ALU:  return bus.alu_res_MEM;
            c_F_RM:   return bus.rm_val_MEM;
            c_F_DEST: return {28'd0, bus.dest_MEM};
            c_F_WBEN: return {31'd0, bus.WB_EN_MEM};
            c_F_MRE:  return {31'd0, bus.MEM_R_EN_MEM};
            c_F_BR:   return bus.branch_address;
            c_F_STAT: return {28'd0, bus.status};
            c_F_HAZ:  return {31'd0, bus.hazard};
            c_F_SEL1: return {30'd0, bus.sel1};
            default:  return {30'd0, bus.sel2};
        endcase
    endfunction

    // Monitor: drains every queued expectation whenever a sample is requested.
    initial begin
        forever begin
            @(smp_ev);
            while (r_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = r_q.pop_front();
                act = field(e.fld);
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input string name, input int f, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.fld  = f;
        e.exp  = v;
        r_q.push_back(e);
    endtask

    task automatic sample();
        -> smp_ev;
        #0;
    endtask

    task automatic defaults();
        bus.FWRD_EN = 0; bus.pc = 0; bus.rn_val = 0; bus.rm_val = 0; bus.val_WB = 0;
        bus.signed_imm_24 = 0; bus.shifter_operand = 0; bus.exe_cmd = 0; bus.dest = 0;
        bus.status_in = 0; bus.WB_EN = 0; bus.MEM_R_EN = 0; bus.MEM_W_EN = 0; bus.S = 0;
        bus.B = 0; bus.imm = 0; bus.src1_fwd = 0; bus.src2_fwd = 0; bus.WB_EN_WB = 0;
        bus.dest_WB = 0; bus.src1_id = 0; bus.src2_id = 0; bus.two_src = 0; bus.move = 0;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic mov_op(input logic [31:0] rm, input logic im, input logic [11:0] so,
                          input logic [31:0] exp, input string name);
        defaults();
        bus.rm_val = rm; bus.imm = im; bus.shifter_operand = so; bus.exe_cmd = 4'b0001;
        at_pos();
        expect_v(name, c_F_ALU, exp);
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        defaults();
        repeat (2) @(posedge clk);
        #1;
        expect_v("rst_alu", c_F_ALU, 0);
        expect_v("rst_wben", c_F_WBEN, 0);
        expect_v("rst_status", c_F_STAT, 0);
        sample();
        rst = 1'b0;

        // ADD immediate
        bus.rn_val = 5; bus.imm = 1; bus.shifter_operand = 12'h00A; bus.exe_cmd = 4'b0010;
        bus.WB_EN = 1; bus.dest = 3;
        at_pos();
        expect_v("add_res", c_F_ALU, 15);
        expect_v("add_dest", c_F_DEST, 3);
        expect_v("add_wben", c_F_WBEN, 1);
        sample();

        // CMP equal then less-than
        defaults();
        bus.rn_val = 3; bus.rm_val = 3; bus.exe_cmd = 4'b0100; bus.S = 1;
        @(negedge clk); #1;
        expect_v("cmp_eq_status", c_F_STAT, 4'b0110);
        sample();
        at_pos();
        bus.rn_val = 2;
        @(negedge clk); #1;
        expect_v("cmp_lt_status", c_F_STAT, 4'b1000);
        sample();
        at_pos();

        // Forwarding: producer of r2 = 0x55
        defaults();
        bus.imm = 1; bus.shifter_operand = 12'h055; bus.exe_cmd = 4'b0001;
        bus.WB_EN = 1; bus.dest = 2;
        at_pos();
        expect_v("mov55", c_F_ALU, 32'h55);
        sample();
        defaults();
        bus.FWRD_EN = 1; bus.WB_EN_WB = 1; bus.dest_WB = 2; bus.val_WB = 32'h77;
        bus.src1_fwd = 2; bus.src2_fwd = 2; bus.rn_val = 32'h11; bus.rm_val = 32'h22;
        bus.imm = 1; bus.exe_cmd = 4'b0010;
        #1;
        expect_v("sel1_mem", c_F_SEL1, 1);
        expect_v("sel2_mem", c_F_SEL2, 1);
        sample();
        at_pos();
        expect_v("fwd_mem_rn", c_F_ALU, 32'h55);
        expect_v("fwd_mem_rm", c_F_RM, 32'h55);
        expect_v("sel1_wb", c_F_SEL1, 2);
        sample();
        at_pos();
        expect_v("fwd_wb_rn", c_F_ALU, 32'h77);
        sample();
        bus.FWRD_EN = 0;
        #1;
        expect_v("sel1_none", c_F_SEL1, 0);
        sample();
        at_pos();
        expect_v("nofwd_rn", c_F_ALU, 32'h11);
        sample();

        // Hazard detection against the instruction in EXE
        defaults();
        bus.WB_EN = 1; bus.dest = 4; bus.src1_id = 4;
        #1; expect_v("haz_nofwd", c_F_HAZ, 1); sample();
        bus.FWRD_EN = 1;
        #1; expect_v("haz_fwd_alu", c_F_HAZ, 0); sample();
        bus.MEM_R_EN = 1;
        #1; expect_v("haz_fwd_load", c_F_HAZ, 1); sample();
        bus.move = 1;
        #1; expect_v("haz_move", c_F_HAZ, 0); sample();
        bus.two_src = 1; bus.src2_id = 4;
        #1; expect_v("haz_src2", c_F_HAZ, 1); sample();
        at_pos();

        // Load-use bubble: producer now in MEM
        defaults();
        bus.src1_id = 4; bus.FWRD_EN = 1;
        #1; expect_v("haz_bubble_fwd", c_F_HAZ, 0); sample();
        bus.FWRD_EN = 0;
        #1; expect_v("haz_mem_nofwd", c_F_HAZ, 1); sample();

        // Branch target
        bus.pc = 32'h100; bus.signed_imm_24 = 24'hFFFFFE;
        #1; expect_v("br_back", c_F_BR, 32'h0F8); sample();
        bus.pc = 32'h200; bus.signed_imm_24 = 24'h000004;
        #1; expect_v("br_fwd", c_F_BR, 32'h210); sample();
        at_pos();

        // Shifter and immediate rotation
        mov_op(32'h80000000, 1'b0, 12'h240, 32'hF8000000, "asr4");
        mov_op(32'h0000000F, 1'b0, 12'h260, 32'hF0000000, "ror4");
        mov_op(32'h0000000F, 1'b0, 12'h220, 32'h00000000, "lsr4");
        mov_op(32'h0, 1'b1, 12'h1FF, 32'hC000003F, "imm_rot");

        // LDR address uses the raw 12-bit offset
        defaults();
        bus.rn_val = 32'h1000; bus.shifter_operand = 12'hFFF; bus.exe_cmd = 4'b0010;
        bus.MEM_R_EN = 1;
        at_pos();
        expect_v("ldr_addr", c_F_ALU, 32'h1FFF);
        expect_v("ldr_mre", c_F_MRE, 1);
        sample();

        // Signed overflow on ADDS
        defaults();
        bus.rn_val = 32'h7FFFFFFF; bus.imm = 1; bus.shifter_operand = 12'h001;
        bus.exe_cmd = 4'b0010; bus.S = 1; bus.WB_EN = 1; bus.dest = 5;
        @(negedge clk); #1;
        expect_v("adds_ovf_status", c_F_STAT, 4'b1001);
        sample();
        at_pos();
        expect_v("adds_ovf_res", c_F_ALU, 32'h80000000);
        sample();

        // Asynchronous reset mid-cycle
        defaults();
        #1 rst = 1'b1;
        #1;
        expect_v("arst_alu", c_F_ALU, 0);
        expect_v("arst_dest", c_F_DEST, 0);
        expect_v("arst_wben", c_F_WBEN, 0);
        expect_v("arst_status", c_F_STAT, 0);
        sample();
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        if (r_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", r_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
